// File: rtl/axi_crossbar_pkg.sv
// Shared types for the crossbar channel arbiter.
package axi_crossbar_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/axi_crossbar_rr_arbiter_if.sv
// Request/grant bundle between the channel sources and the round-robin arbiter.
interface axi_crossbar_rr_arbiter_if #(
  parameter int REQ_NB = 4
);
  localparam int REQ_ID_W = $clog2(REQ_NB);

  logic [REQ_NB-1:0]   i_req;
  logic [REQ_NB-1:0]   i_last;
  logic                i_ready;
  logic [REQ_NB-1:0]   o_grant;
  logic [REQ_ID_W-1:0] o_grant_id;
  logic                o_grant_valid;

  modport master (
    output i_req, i_last, i_ready,
    input  o_grant, o_grant_id, o_grant_valid
  );

  modport slave (
    input  i_req, i_last, i_ready,
    output o_grant, o_grant_id, o_grant_valid
  );

endinterface

// File: rtl/axi_crossbar_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping around.
module axi_crossbar_rr_pick #(
  parameter int REQ_NB = 4,
  localparam int REQ_ID_W = $clog2(REQ_NB)
) (
  input  logic [REQ_NB-1:0]   req,
  input  logic [REQ_ID_W-1:0] ptr,
  output logic                found,
  output logic [REQ_ID_W-1:0] idx
);

  logic [2*REQ_NB-1:0] masked;

  // Lower copy masked below ptr; the upper copy supplies the wrapped-around candidates.
  always_comb begin
    masked = {req, req};
    for (int i = 0; i < REQ_NB; i++) begin
      if (i < int'(ptr)) masked[i] = 1'b0;
    end
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < 2*REQ_NB; i++) begin
      if (!found && masked[i]) begin
        found = 1'b1;
        idx   = (i >= REQ_NB) ? REQ_ID_W'(i - REQ_NB) : REQ_ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/axi_crossbar_rr_arbiter.sv
// Round-robin arbiter that locks a grant until the granted source's last beat is accepted.
module axi_crossbar_rr_arbiter
  import axi_crossbar_pkg::*;
#(
  parameter int REQ_NB = 4
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      srst,
  axi_crossbar_rr_arbiter_if.slave  bus
);

  localparam int REQ_ID_W = $clog2(REQ_NB);

  arb_state_t          state_q, state_d;
  logic [REQ_ID_W-1:0] ptr_q, ptr_d;
  logic [REQ_NB-1:0]   grant_q, grant_d;
  logic [REQ_ID_W-1:0] id_q, id_d;
  logic                valid_q, valid_d;

  logic                pick_found;
  logic [REQ_ID_W-1:0] pick_idx;
  logic                hs;
  logic                last_beat;

  axi_crossbar_rr_pick #(.REQ_NB(REQ_NB)) u_pick (
    .req   (bus.i_req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign hs        = bus.i_req[id_q] & bus.i_ready;
  assign last_beat = bus.i_last[id_q];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    id_d    = id_q;
    valid_d = valid_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d           = ARB_BUSY;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          id_d              = pick_idx;
          valid_d           = 1'b1;
        end
      end
      ARB_BUSY: begin
        // Lock until the final beat; a dropped request mid-burst keeps the grant.
        if (hs && last_beat) begin
          state_d = ARB_IDLE;
          grant_d = '0;
          id_d    = '0;
          valid_d = 1'b0;
          ptr_d   = (id_q == REQ_ID_W'(REQ_NB - 1)) ? '0 : id_q + REQ_ID_W'(1);
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
        id_d    = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
    end else if (srst) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      valid_q <= valid_d;
    end
  end

  assign bus.o_grant       = grant_q;
  assign bus.o_grant_id    = id_q;
  assign bus.o_grant_valid = valid_q;

`ifndef SYNTHESIS
  a_grant_onehot0: assert property (@(posedge aclk) disable iff (!aresetn)
    $onehot0(grant_q));
  a_valid_matches: assert property (@(posedge aclk) disable iff (!aresetn)
    valid_q == (|grant_q));
  a_id_matches: assert property (@(posedge aclk) disable iff (!aresetn)
    grant_q == (REQ_NB'(valid_q) << id_q));
`endif

endmodule

// File: tb/tb_axi_crossbar_rr_arbiter.sv
// Scoreboard bench for the round-robin arbiter: stimulus queues expected grants, a monitor checks them.
module tb_axi_crossbar_rr_arbiter;

  typedef struct {
    int id;
    int dur;
  } exp_t;

  logic aclk;
  logic aresetn;
  logic srst;
  int   checks;
  int   errors;
  bit   soak;
  exp_t exp_q[$];

  axi_crossbar_rr_arbiter_if #(.REQ_NB(4)) bus ();

  axi_crossbar_rr_arbiter #(.REQ_NB(4)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .srst    (srst),
    .bus     (bus.slave)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_val);
    checks++;
    if (act !== req_val) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req_val, $time);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic expect_grant(input int id, input int dur);
    exp_t e;
    e.id  = id;
    e.dur = dur;
    exp_q.push_back(e);
  endtask

  // Monitor: pop an expectation at each new grant, check the hold id and duration.
  initial begin
    exp_t cur;
    bit   prev_v;
    int   dur_cnt;
    cur     = '{id: 0, dur: 0};
    prev_v  = 1'b0;
    dur_cnt = 0;
    forever begin
      @(negedge aclk);
      if (soak) begin
        chk("inv_onehot0", 32'($onehot0(bus.o_grant)), 32'd1);
        chk("inv_id_map", 32'(bus.o_grant), 32'(32'(bus.o_grant_valid) << bus.o_grant_id));
      end else begin
        if (bus.o_grant_valid && !prev_v) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_grant", 32'(bus.o_grant), 32'd0);
            cur = '{id: 0, dur: 0};
          end else begin
            cur = exp_q.pop_front();
            chk("grant_id", 32'(bus.o_grant_id), 32'(cur.id));
            chk("grant_vec", 32'(bus.o_grant), 32'(32'd1 << cur.id));
          end
          dur_cnt = 1;
        end else if (bus.o_grant_valid) begin
          chk("grant_hold_id", 32'(bus.o_grant_id), 32'(cur.id));
          dur_cnt++;
        end
        if (!bus.o_grant_valid && prev_v && cur.dur != 0)
          chk("grant_duration", 32'(dur_cnt), 32'(cur.dur));
      end
      prev_v = bus.o_grant_valid;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] rdy_pat;
    int         beats;
    checks       = 0;
    errors       = 0;
    soak         = 1'b0;
    aresetn      = 1'b0;
    srst         = 1'b0;
    bus.i_req    = '0;
    bus.i_last   = '0;
    bus.i_ready  = 1'b0;
    #1;
    chk("reset_grant", 32'(bus.o_grant), 32'd0);
    chk("reset_valid", 32'(bus.o_grant_valid), 32'd0);
    chk("reset_id", 32'(bus.o_grant_id), 32'd0);
    @(posedge aclk);
    @(posedge aclk);
    #1 aresetn = 1'b1;

    // Async reset in the middle of a locked grant to requester 1.
    expect_grant(1, 0);
    bus.i_req   = 4'b0010;
    bus.i_last  = 4'b0010;
    bus.i_ready = 1'b0;
    step();
    step();
    step();
    chk("midburst_grant", 32'(bus.o_grant), 32'h2);
    #2 aresetn = 1'b0;
    #1;
    chk("async_rst_grant", 32'(bus.o_grant), 32'd0);
    chk("async_rst_valid", 32'(bus.o_grant_valid), 32'd0);
    bus.i_req = '0;
    step();
    aresetn = 1'b1;
    expect_grant(0, 1);
    bus.i_req   = 4'b1111;
    bus.i_last  = 4'b1111;
    bus.i_ready = 1'b1;
    step();
    step();
    bus.i_req = '0;
    step();

    // Single request from source 2, ptr moves to 3.
    expect_grant(2, 1);
    bus.i_req = 4'b0100;
    step();
    step();
    bus.i_req = '0;
    step();

    // Wrap: ptr=3 with sources 0 and 3 requesting.
    expect_grant(3, 1);
    expect_grant(0, 1);
    bus.i_req = 4'b1001;
    repeat (4) step();
    bus.i_req = '0;
    step();

    // srst on the same edge as the final handshake of a grant to source 2.
    expect_grant(2, 0);
    bus.i_req   = 4'b0100;
    bus.i_ready = 1'b0;
    step();
    step();
    bus.i_ready = 1'b1;
    srst        = 1'b1;
    step();
    chk("srst_grant", 32'(bus.o_grant), 32'd0);
    chk("srst_valid", 32'(bus.o_grant_valid), 32'd0);
    srst      = 1'b0;
    bus.i_req = '0;
    step();

    // Fairness from ptr=0 proves srst cleared the pointer.
    expect_grant(0, 1);
    expect_grant(1, 1);
    expect_grant(2, 1);
    expect_grant(3, 1);
    expect_grant(0, 1);
    bus.i_req = 4'b1111;
    repeat (10) step();
    bus.i_req = '0;
    step();

    // Bring ptr back to 0 through source 3.
    expect_grant(3, 1);
    bus.i_req = 4'b1000;
    step();
    step();
    bus.i_req = '0;
    step();

    // Burst lock: source 0 four beats with stalls while source 1 waits.
    expect_grant(0, 6);
    expect_grant(1, 1);
    rdy_pat     = 6'b101101;
    beats       = 0;
    bus.i_req   = 4'b0011;
    bus.i_last  = 4'b0010;
    bus.i_ready = 1'b0;
    step();
    for (int c = 0; c < 6; c++) begin
      bus.i_ready   = rdy_pat[c];
      bus.i_last[0] = (beats == 3);
      step();
      if (rdy_pat[c]) beats++;
    end
    bus.i_req   = 4'b0010;
    bus.i_last  = 4'b0010;
    bus.i_ready = 1'b1;
    step();
    step();
    bus.i_req = '0;
    repeat (3) step();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // Random soak; invariants checked by the monitor and the RTL assertions.
    soak = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      bus.i_req   = 4'($urandom_range(0, 15));
      bus.i_last  = 4'($urandom_range(0, 15));
      bus.i_ready = 1'($urandom_range(0, 1));
      step();
    end
    bus.i_req = '0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
